multi_target_firing_unit: RTL and testbench

- Parametrised successor to the single-bird firing datapath.
- Resolves a player shot against up to NUM_BIRDS birds, tracks the remaining ammunition and a sticky per-bird hit mask, and reports escapes at reload.
- Sits between the game-control FSM, which issues fire/reload requests, and the bird movers, which supply positions and fly/fall flags.
- Scans birds sequentially, one per cycle, so the comparator logic is shared.

---
 rtl/firing_pkg.sv | 24 ++
 rtl/multi_target_firing_unit_box_overlap.sv | 28 ++
 rtl/multi_target_firing_unit.sv | 234 +++++++++++++++++++++++
 tb/tb_multi_target_firing_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/firing_pkg.sv
// Shared definitions for the multi-target firing datapath: FSM state encoding,
// default coordinate widths and the default bird hitbox / player cursor extents.
// No ports; imported by multi_target_firing_unit and box_overlap.
package firing_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        RESOLVE = 2'd2,
        RELOAD  = 2'd3
    } fire_state_t;

    localparam int DEF_XW       = 8;
    localparam int DEF_YW       = 8;
    localparam int DEF_HITBOX_X = 14;
    localparam int DEF_HITBOX_Y = 9;
    localparam int DEF_CURSOR   = 3;

    // Index width for n channels; a single channel still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_target_firing_unit_box_overlap.sv
// box_overlap: 1-D interval overlap between [a_pos, a_pos+EXT_A-1] and
// [b_pos, b_pos+EXT_B-1]. Purely combinational (zero latency, no backpressure).
// Ports: a_pos/b_pos interval left edges (W bits), overlap = intervals share a pixel.
module box_overlap #(
    parameter int W     = 8,
    parameter int EXT_A = 14,
    parameter int EXT_B = 3
) (
    input  logic [W-1:0] a_pos,
    input  logic [W-1:0] b_pos,
    output logic         overlap
);
    localparam logic [W:0] A_OFF = (W+1)'(EXT_A - 1);
    localparam logic [W:0] B_OFF = (W+1)'(EXT_B - 1);

    logic [W:0] a_ext;
    logic [W:0] b_ext;
    logic [W:0] a_end;
    logic [W:0] b_end;

    // One extra bit so a box near the screen edge never wraps back to zero.
    assign a_ext   = {1'b0, a_pos};
    assign b_ext   = {1'b0, b_pos};
    assign a_end   = a_ext + A_OFF;
    assign b_end   = b_ext + B_OFF;
    assign overlap = (b_ext <= a_end) && (a_ext <= b_end);

endmodule

// File: rtl/multi_target_firing_unit.sv
// Resolves a player shot against NUM_BIRDS birds, scanning one bird per cycle through
// one shared X/Y comparator pair; tracks ammo, a sticky hit mask and reload escapes.
// Latency: fire accepted in cycle N -> done in cycle N+NUM_BIRDS+1; requests outside IDLE are dropped.
// Ports: clk/reset (async, active-high), fire_req/reload_req, cursor and packed bird
// coordinates, bird_busy; outputs busy, done, hit, hit_idx, hit_mask, remaining_shots,
// escape_mask. Optional macro FIRING_SCORE_EN adds saturating score and perfect_round.
module multi_target_firing_unit
    import firing_pkg::*;
#(
    parameter int NUM_BIRDS = 2,
    parameter int SHOTS     = 3,
    parameter int XW        = DEF_XW,
    parameter int YW        = DEF_YW,
    parameter int HITBOX_X  = DEF_HITBOX_X,
    parameter int HITBOX_Y  = DEF_HITBOX_Y,
    parameter int CURSOR    = DEF_CURSOR,
    localparam int SW       = $clog2(SHOTS + 1),
    localparam int IW       = idx_width(NUM_BIRDS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fire_req,
    input  logic                    reload_req,
    input  logic [XW-1:0]           x_player,
    input  logic [YW-1:0]           y_player,
    input  logic [NUM_BIRDS*XW-1:0] x_bird,
    input  logic [NUM_BIRDS*YW-1:0] y_bird,
    input  logic [NUM_BIRDS-1:0]    bird_busy,
    output logic                    busy,
    output logic                    done,
    output logic                    hit,
    output logic [IW-1:0]           hit_idx,
    output logic [NUM_BIRDS-1:0]    hit_mask,
    output logic [SW-1:0]           remaining_shots,
    output logic [NUM_BIRDS-1:0]    escape_mask
`ifdef FIRING_SCORE_EN
    ,
    output logic [15:0]             score,
    output logic                    perfect_round
`endif
);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_BIRDS - 1);
    localparam logic [SW-1:0] FULL_SHOTS = SW'(SHOTS);

    fire_state_t             state_q, state_d;
    logic [XW-1:0]           xp_q, xp_d;
    logic [YW-1:0]           yp_q, yp_d;
    logic [NUM_BIRDS*XW-1:0] xb_q, xb_d;
    logic [NUM_BIRDS*YW-1:0] yb_q, yb_d;
    logic [NUM_BIRDS-1:0]    busy_l_q, busy_l_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    found_q, found_d;
    logic [IW-1:0]           found_idx_q, found_idx_d;
    logic [NUM_BIRDS-1:0]    hit_mask_q, hit_mask_d;
    logic [SW-1:0]           shots_q, shots_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    hit_q, hit_d;
    logic [IW-1:0]           hit_idx_q, hit_idx_d;
    logic [NUM_BIRDS-1:0]    escape_q, escape_d;
`ifdef FIRING_SCORE_EN
    logic [15:0]             score_q, score_d;
    logic                    perfect_q, perfect_d;
`endif

    // Currently scanned bird, selected from the snapshot taken at fire time.
    logic [XW-1:0] xb_cur;
    logic [YW-1:0] yb_cur;
    logic          cur_busy, cur_masked;
    logic          ov_x, ov_y, cand, found_now;
    logic [IW-1:0] sel_idx;

    always_comb begin
        xb_cur     = '0;
        yb_cur     = '0;
        cur_busy   = 1'b0;
        cur_masked = 1'b0;
        for (int i = 0; i < NUM_BIRDS; i++) begin
            if (idx_q == IW'(i)) begin
                xb_cur     = xb_q[i*XW +: XW];
                yb_cur     = yb_q[i*YW +: YW];
                cur_busy   = busy_l_q[i];
                cur_masked = hit_mask_q[i];
            end
        end
    end

    box_overlap #(.W(XW), .EXT_A(HITBOX_X), .EXT_B(CURSOR)) u_ov_x (
        .a_pos(xb_cur), .b_pos(xp_q), .overlap(ov_x)
    );
    box_overlap #(.W(YW), .EXT_A(HITBOX_Y), .EXT_B(CURSOR)) u_ov_y (
        .a_pos(yb_cur), .b_pos(yp_q), .overlap(ov_y)
    );

    assign cand      = ~cur_busy & ~cur_masked & ov_x & ov_y;
    // Lowest index wins: once a candidate is recorded, later ones are ignored.
    assign found_now = found_q | cand;
    assign sel_idx   = found_q ? found_idx_q : idx_q;

    always_comb begin
        state_d     = state_q;
        xp_d        = xp_q;
        yp_d        = yp_q;
        xb_d        = xb_q;
        yb_d        = yb_q;
        busy_l_d    = busy_l_q;
        idx_d       = idx_q;
        found_d     = found_q;
        found_idx_d = found_idx_q;
        hit_mask_d  = hit_mask_q;
        shots_d     = shots_q;
        busy_d      = busy_q;
        hit_idx_d   = hit_idx_q;
        done_d      = 1'b0;
        hit_d       = 1'b0;
        escape_d    = '0;
`ifdef FIRING_SCORE_EN
        score_d     = score_q;
        perfect_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (reload_req) begin
                    state_d    = RELOAD;
                    escape_d   = ~hit_mask_q;
                    hit_mask_d = '0;
                    shots_d    = FULL_SHOTS;
`ifdef FIRING_SCORE_EN
                    perfect_d  = &hit_mask_q;
`endif
                end else if (fire_req && (shots_q != '0)) begin
                    state_d     = SCAN;
                    xp_d        = x_player;
                    yp_d        = y_player;
                    xb_d        = x_bird;
                    yb_d        = y_bird;
                    busy_l_d    = bird_busy;
                    shots_d     = shots_q - SW'(1);
                    idx_d       = '0;
                    found_d     = 1'b0;
                    found_idx_d = '0;
                    busy_d      = 1'b1;
                end
            end
            SCAN: begin
                if (cand && !found_q) begin
                    found_d     = 1'b1;
                    found_idx_d = idx_q;
                end
                if (idx_q == LAST_IDX) begin
                    // Outputs are registered, so the result is staged here and
                    // becomes visible during the RESOLVE cycle.
                    state_d   = RESOLVE;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    hit_d     = found_now;
                    hit_idx_d = found_now ? sel_idx : '0;
                    if (found_now) begin
                        hit_mask_d = hit_mask_q | (NUM_BIRDS'(1) << sel_idx);
`ifdef FIRING_SCORE_EN
                        if (score_q != 16'hFFFF) begin
                            score_d = score_q + 16'd1;
                        end
`endif
                    end
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            RESOLVE: state_d = IDLE;
            RELOAD:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            xp_q        <= '0;
            yp_q        <= '0;
            xb_q        <= '0;
            yb_q        <= '0;
            busy_l_q    <= '0;
            idx_q       <= '0;
            found_q     <= 1'b0;
            found_idx_q <= '0;
            hit_mask_q  <= '0;
            shots_q     <= FULL_SHOTS;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hit_q       <= 1'b0;
            hit_idx_q   <= '0;
            escape_q    <= '0;
`ifdef FIRING_SCORE_EN
            score_q     <= '0;
            perfect_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            xp_q        <= xp_d;
            yp_q        <= yp_d;
            xb_q        <= xb_d;
            yb_q        <= yb_d;
            busy_l_q    <= busy_l_d;
            idx_q       <= idx_d;
            found_q     <= found_d;
            found_idx_q <= found_idx_d;
            hit_mask_q  <= hit_mask_d;
            shots_q     <= shots_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            hit_q       <= hit_d;
            hit_idx_q   <= hit_idx_d;
            escape_q    <= escape_d;
`ifdef FIRING_SCORE_EN
            score_q     <= score_d;
            perfect_q   <= perfect_d;
`endif
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign hit             = hit_q;
    assign hit_idx         = hit_idx_q;
    assign hit_mask        = hit_mask_q;
    assign remaining_shots = shots_q;
    assign escape_mask     = escape_q;
`ifdef FIRING_SCORE_EN
    assign score           = score_q;
    assign perfect_round   = perfect_q;
`endif

endmodule

// File: tb/tb_multi_target_firing_unit.sv
// Directed bench for multi_target_firing_unit with NUM_BIRDS=2, SHOTS=3, 8-bit coords.
// Inputs are driven and outputs sampled on the falling edge; the fire-request cycle is
// cycle 0, so a resolved shot must show done in cycle 3.
module tb_multi_target_firing_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fire_req = 1'b0;
    logic        reload_req = 1'b0;
    logic [7:0]  x_player = '0;
    logic [7:0]  y_player = '0;
    logic [15:0] x_bird = '0;
    logic [15:0] y_bird = '0;
    logic [1:0]  bird_busy = '0;
    logic        busy, done, hit;
    logic [0:0]  hit_idx;
    logic [1:0]  hit_mask;
    logic [1:0]  remaining_shots;
    logic [1:0]  escape_mask;
`ifdef FIRING_SCORE_EN
    logic [15:0] score;
    logic        perfect_round;
`endif

    int errors = 0;
    int checks = 0;

    // Results of the most recent shot / reload.
    int         s_done_cyc, s_done_cnt;
    logic       s_hit, s_busy1;
    logic [0:0] s_idx;
    logic [1:0] r_esc, r_mask, r_shots;
    int         r_esc_later, r_done, r_perf;

    always #5 clk = ~clk;

    multi_target_firing_unit dut (
        .clk(clk), .reset(reset), .fire_req(fire_req), .reload_req(reload_req),
        .x_player(x_player), .y_player(y_player), .x_bird(x_bird), .y_bird(y_bird),
        .bird_busy(bird_busy), .busy(busy), .done(done), .hit(hit), .hit_idx(hit_idx),
        .hit_mask(hit_mask), .remaining_shots(remaining_shots), .escape_mask(escape_mask)
`ifdef FIRING_SCORE_EN
        , .score(score), .perfect_round(perfect_round)
`endif
    );

    task automatic set_birds(input logic [7:0] x0, y0, x1, y1, input logic [1:0] bb);
        x_bird    = {x1, x0};
        y_bird    = {y1, y0};
        bird_busy = bb;
    endtask

    // Issue one fire request and watch a fixed 8-cycle window for done.
    task automatic shot(input logic [7:0] xp, yp);
        @(negedge clk);
        x_player = xp; y_player = yp; fire_req = 1'b1;
        @(negedge clk);
        fire_req = 1'b0;
        s_busy1 = busy; s_done_cyc = 0; s_done_cnt = 0; s_hit = 1'b0; s_idx = '0;
        for (int c = 1; c <= 8; c++) begin
            if (done) begin
                if (s_done_cnt == 0) begin
                    s_done_cyc = c; s_hit = hit; s_idx = hit_idx;
                end
                s_done_cnt++;
            end
            if (c < 8) @(negedge clk);
        end
    endtask

    // Issue a reload (optionally with a simultaneous fire) and watch 5 cycles.
    task automatic do_reload(input logic with_fire);
        @(negedge clk);
        reload_req = 1'b1; fire_req = with_fire;
        @(negedge clk);
        reload_req = 1'b0; fire_req = 1'b0;
        r_esc = escape_mask; r_mask = hit_mask; r_shots = remaining_shots;
        r_esc_later = 0; r_done = 0; r_perf = 0;
        for (int c = 0; c < 5; c++) begin
            if (done) r_done++;
            if (c > 0 && escape_mask != 2'b00) r_esc_later++;
`ifdef FIRING_SCORE_EN
            if (perfect_round) r_perf++;
`endif
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0d expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0d expected 0", done); end
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %0d expected 0", hit); end
        checks++; if (hit_idx !== 1'b0) begin errors++; $display("FAIL reset_hit_idx: got %0d expected 0", hit_idx); end
        checks++; if (hit_mask !== 2'b00) begin errors++; $display("FAIL reset_hit_mask: got %b expected 00", hit_mask); end
        checks++; if (remaining_shots !== 2'd3) begin errors++; $display("FAIL reset_shots: got %0d expected 3", remaining_shots); end
        checks++; if (escape_mask !== 2'b00) begin errors++; $display("FAIL reset_escape: got %b expected 00", escape_mask); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_hit();
        set_birds(8'd15, 8'd15, 8'd200, 8'd200, 2'b00);
        shot(8'd20, 8'd20);
        checks++; if (s_busy1 !== 1'b1) begin errors++; $display("FAIL basic_busy: got %0d expected 1", s_busy1); end
        checks++; if (s_done_cyc != 3) begin errors++; $display("FAIL basic_latency: got cycle %0d expected 3", s_done_cyc); end
        checks++; if (s_done_cnt != 1) begin errors++; $display("FAIL basic_done_width: got %0d expected 1", s_done_cnt); end
        checks++; if (s_hit !== 1'b1) begin errors++; $display("FAIL basic_hit: got %0d expected 1", s_hit); end
        checks++; if (s_idx !== 1'b0) begin errors++; $display("FAIL basic_idx: got %0d expected 0", s_idx); end
        checks++; if (hit_mask !== 2'b01) begin errors++; $display("FAIL basic_mask: got %b expected 01", hit_mask); end
        checks++; if (remaining_shots !== 2'd2) begin errors++; $display("FAIL basic_shots: got %0d expected 2", remaining_shots); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %0d expected 0", busy); end
    endtask

    task automatic test_hitbox_edge();
        do_reload(1'b0);
        set_birds(8'd100, 8'd100, 8'd15, 8'd10, 2'b00);
        shot(8'd28, 8'd10);   // cursor left edge on bird1's last pixel column 15+13
        checks++; if (s_hit !== 1'b1) begin errors++; $display("FAIL edge_hit: got %0d expected 1", s_hit); end
        checks++; if (s_idx !== 1'b1) begin errors++; $display("FAIL edge_idx: got %0d expected 1", s_idx); end
        shot(8'd29, 8'd10);   // one pixel beyond the hitbox
        checks++; if (s_done_cnt != 1) begin errors++; $display("FAIL edge_miss_done: got %0d expected 1", s_done_cnt); end
        checks++; if (s_hit !== 1'b0) begin errors++; $display("FAIL edge_miss: got %0d expected 0", s_hit); end
        checks++; if (hit_mask !== 2'b10) begin errors++; $display("FAIL edge_mask: got %b expected 10", hit_mask); end
        checks++; if (remaining_shots !== 2'd1) begin errors++; $display("FAIL edge_shots: got %0d expected 1", remaining_shots); end
    endtask

    task automatic test_priority_and_ammo();
        do_reload(1'b0);
        set_birds(8'd15, 8'd15, 8'd16, 8'd16, 2'b00);
        shot(8'd20, 8'd20);
        checks++; if (s_hit !== 1'b1 || s_idx !== 1'b0) begin errors++; $display("FAIL prio_first: got hit=%0d idx=%0d expected hit=1 idx=0", s_hit, s_idx); end
        shot(8'd20, 8'd20);
        checks++; if (s_hit !== 1'b1 || s_idx !== 1'b1) begin errors++; $display("FAIL prio_masked: got hit=%0d idx=%0d expected hit=1 idx=1", s_hit, s_idx); end
        shot(8'd20, 8'd20);
        checks++; if (s_hit !== 1'b0) begin errors++; $display("FAIL prio_all_dead: got %0d expected 0", s_hit); end
        checks++; if (remaining_shots !== 2'd0) begin errors++; $display("FAIL prio_empty: got %0d expected 0", remaining_shots); end
        shot(8'd20, 8'd20);
        checks++; if (s_done_cnt != 0) begin errors++; $display("FAIL prio_no_ammo_done: got %0d expected 0", s_done_cnt); end
        checks++; if (s_busy1 !== 1'b0) begin errors++; $display("FAIL prio_no_ammo_busy: got %0d expected 0", s_busy1); end
        do_reload(1'b0);
        checks++; if (r_esc !== 2'b00) begin errors++; $display("FAIL prio_escape_none: got %b expected 00", r_esc); end
    endtask

    task automatic test_screen_edge_and_busy();
        set_birds(8'd250, 8'd250, 8'd0, 8'd0, 2'b01);
        shot(8'd254, 8'd254);
        checks++; if (s_hit !== 1'b0) begin errors++; $display("FAIL busy_bird: got %0d expected 0", s_hit); end
        set_birds(8'd250, 8'd250, 8'd0, 8'd0, 2'b00);
        shot(8'd254, 8'd254);
        checks++; if (s_hit !== 1'b1 || s_idx !== 1'b0) begin errors++; $display("FAIL screen_edge: got hit=%0d idx=%0d expected hit=1 idx=0", s_hit, s_idx); end
    endtask

    task automatic test_reload();
        do_reload(1'b0);
        set_birds(8'd100, 8'd100, 8'd15, 8'd10, 2'b00);
        shot(8'd28, 8'd10);
        do_reload(1'b0);
        checks++; if (r_esc !== 2'b01) begin errors++; $display("FAIL reload_escape: got %b expected 01", r_esc); end
        checks++; if (r_esc_later != 0) begin errors++; $display("FAIL reload_escape_width: got %0d extra cycles expected 0", r_esc_later); end
        checks++; if (r_mask !== 2'b00) begin errors++; $display("FAIL reload_mask: got %b expected 00", r_mask); end
        checks++; if (r_shots !== 2'd3) begin errors++; $display("FAIL reload_shots: got %0d expected 3", r_shots); end
        shot(8'd0, 8'd200);   // a miss, leaves 2 shots
        do_reload(1'b1);
        checks++; if (r_done != 0) begin errors++; $display("FAIL simul_done: got %0d expected 0", r_done); end
        checks++; if (r_shots !== 2'd3) begin errors++; $display("FAIL simul_shots: got %0d expected 3", r_shots); end
        checks++; if (remaining_shots !== 2'd3) begin errors++; $display("FAIL simul_shots_after: got %0d expected 3", remaining_shots); end
    endtask

    task automatic test_reset_mid_scan();
        int dcnt;
        set_birds(8'd15, 8'd15, 8'd200, 8'd200, 2'b00);
        @(negedge clk);
        x_player = 8'd20; y_player = 8'd20; fire_req = 1'b1;
        @(negedge clk);
        fire_req = 1'b0;
        checks++; if (remaining_shots !== 2'd2) begin errors++; $display("FAIL abort_pre_shots: got %0d expected 2", remaining_shots); end
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0d expected 0", busy); end
        checks++; if (remaining_shots !== 2'd3) begin errors++; $display("FAIL abort_shots: got %0d expected 3", remaining_shots); end
        @(negedge clk);
        reset = 1'b0;
        dcnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        checks++; if (dcnt != 0) begin errors++; $display("FAIL abort_done: got %0d expected 0", dcnt); end
        checks++; if (hit_mask !== 2'b00) begin errors++; $display("FAIL abort_mask: got %b expected 00", hit_mask); end
    endtask

`ifdef FIRING_SCORE_EN
    task automatic test_score();
        set_birds(8'd15, 8'd15, 8'd40, 8'd15, 2'b00);
        shot(8'd20, 8'd20);
        shot(8'd45, 8'd20);
        checks++; if (score !== 16'd2) begin errors++; $display("FAIL score_count: got %0d expected 2", score); end
        do_reload(1'b0);
        checks++; if (r_perf != 1) begin errors++; $display("FAIL perfect_pulse: got %0d expected 1", r_perf); end
        checks++; if (score !== 16'd2) begin errors++; $display("FAIL score_kept: got %0d expected 2", score); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_hit();
        test_hitbox_edge();
        test_priority_and_ammo();
        test_screen_edge_and_busy();
        test_reload();
        test_reset_mid_scan();
`ifdef FIRING_SCORE_EN
        test_score();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
